// File: rtl/instr_fetch_queue.sv
// Instruction prefetch FIFO: buffers raw words from instruction memory
// and presents the oldest one split into opcode and address fields.
module instr_fetch_queue #(
    parameter int OPCODE_W = 3,
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 4,
    localparam int INS_W   = OPCODE_W + ADDR_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [INS_W-1:0]    in_ins,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [OPCODE_W-1:0] opcode_out,
    output logic [ADDR_W-1:0]   address_out,
    output logic [CNT_W-1:0]    count
);

    logic [INS_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;
    logic [INS_W-1:0] head;

    assign in_ready  = (count_q != CNT_W'(DEPTH));
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    assign head        = mem_q[rd_ptr_q];
    assign opcode_out  = out_valid ? head[INS_W-1:ADDR_W] : '0;
    assign address_out = out_valid ? head[ADDR_W-1:0] : '0;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // DEPTH is a power of two, so pointer overflow is the wrap
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            if (push && !pop)      count_d = count_q + CNT_W'(1);
            else if (pop && !push) count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        if (push && !flush) mem_q[wr_ptr_q] <= in_ins;
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue: vector table plus hand sequences
// for wrap, flush priority and asynchronous reset.
module tb_instr_fetch_queue;

    logic       clock = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic [7:0] in_ins;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] opcode_out;
    logic [4:0] address_out;
    logic [2:0] count;

    int checks   = 0;
    int failures = 0;

    instr_fetch_queue #(.OPCODE_W(3), .ADDR_W(5), .DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ins      (in_ins),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .opcode_out  (opcode_out),
        .address_out (address_out),
        .count       (count)
    );

    always #5 clock = ~clock;

    // Expected fields describe the outputs seen before this vector's edge
    typedef struct {
        logic       fl;
        logic       iv;
        logic [7:0] ins;
        logic       ordy;
        logic       e_ir;
        logic       e_ov;
        logic [2:0] e_op;
        logic [4:0] e_ad;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ir, input logic ov,
                           input logic [2:0] op, input logic [4:0] ad,
                           input logic [2:0] cnt);
        chk({tag, ".in_ready"}, int'(in_ready), int'(ir));
        chk({tag, ".out_valid"}, int'(out_valid), int'(ov));
        chk({tag, ".opcode"}, int'(opcode_out), int'(op));
        chk({tag, ".address"}, int'(address_out), int'(ad));
        chk({tag, ".count"}, int'(count), int'(cnt));
    endtask

    task automatic drive(input logic fl, input logic iv,
                         input logic [7:0] d, input logic ordy);
        flush     = fl;
        in_valid  = iv;
        in_ins    = d;
        out_ready = ordy;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        vecs[0]  = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 0};
        vecs[1]  = '{0, 1, 8'hA7, 0, 1, 0, 0, 0, 0};
        vecs[2]  = '{0, 0, 8'h00, 0, 1, 1, 5, 7, 1};
        vecs[3]  = '{0, 0, 8'h00, 1, 1, 1, 5, 7, 1};
        vecs[4]  = '{0, 0, 8'h00, 1, 1, 0, 0, 0, 0};
        vecs[5]  = '{0, 1, 8'h01, 0, 1, 0, 0, 0, 0};
        vecs[6]  = '{0, 1, 8'h22, 0, 1, 1, 0, 1, 1};
        vecs[7]  = '{0, 1, 8'h43, 0, 1, 1, 0, 1, 2};
        vecs[8]  = '{0, 1, 8'h64, 0, 1, 1, 0, 1, 3};
        vecs[9]  = '{0, 1, 8'h85, 0, 0, 1, 0, 1, 4};
        vecs[10] = '{0, 1, 8'h99, 1, 0, 1, 0, 1, 4};
        vecs[11] = '{0, 0, 8'h00, 1, 1, 1, 1, 2, 3};
        vecs[12] = '{0, 0, 8'h00, 1, 1, 1, 2, 3, 2};
        vecs[13] = '{0, 0, 8'h00, 1, 1, 1, 3, 4, 1};
        vecs[14] = '{0, 0, 8'h00, 0, 1, 0, 0, 0, 0};

        reset = 1'b1;
        drive(0, 0, 8'h00, 0);
        #12;
        chk_all("reset", 1, 0, 0, 0, 0);
        reset = 1'b0;
        step();

        foreach (vecs[i]) begin
            drive(vecs[i].fl, vecs[i].iv, vecs[i].ins, vecs[i].ordy);
            chk_all($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                    vecs[i].e_op, vecs[i].e_ad, vecs[i].e_cnt);
            step();
        end

        // Simultaneous push/pop across pointer wrap
        drive(0, 1, 8'h10, 0);
        step();
        drive(0, 1, 8'h11, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            logic [7:0] exp_w;
            exp_w = 8'h10 + 8'(i);
            drive(0, 1, 8'h12 + 8'(i), 1);
            chk($sformatf("wrap%0d.count", i), int'(count), 2);
            chk($sformatf("wrap%0d.word", i),
                int'({opcode_out, address_out}), int'(exp_w));
            step();
        end

        // Flush wins over push and pop in the same cycle
        drive(0, 1, 8'h77, 0);
        step();
        chk("preflush.count", int'(count), 3);
        drive(1, 1, 8'hFF, 1);
        step();
        drive(0, 0, 8'h00, 0);
        chk_all("flush", 1, 0, 0, 0, 0);
        drive(0, 1, 8'h3C, 0);
        step();
        drive(0, 0, 8'h00, 0);
        chk_all("postflush", 1, 1, 1, 28, 1);

        // Asynchronous reset between edges
        drive(0, 1, 8'h4B, 0);
        step();
        drive(0, 0, 8'h00, 0);
        chk("prerst.count", int'(count), 2);
        #2;
        reset = 1'b1;
        #1;
        chk_all("asyncrst", 1, 0, 0, 0, 0);
        #1;
        reset = 1'b0;
        step();
        chk_all("rst_idle", 1, 0, 0, 0, 0);
        drive(0, 1, 8'h5A, 0);
        step();
        drive(0, 0, 8'h00, 0);
        chk_all("rst_push", 1, 1, 2, 26, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
